// File: rtl/sfifo_wr_arbiter.sv
// +--------------------------------------------------------------------------+
// | sfifo_wr_arbiter                                                         |
// | Round-robin, packet-locked arbiter sharing one FIFO write port.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module sfifo_wr_arbiter #(
  parameter int WIDTH        = 8,
  parameter int N_REQ        = 4,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [N_REQ-1:0]       i_req_valid,
  input  logic [N_REQ*WIDTH-1:0] i_req_data,
  input  logic [N_REQ-1:0]       i_req_last,
  output logic [N_REQ-1:0]       o_req_ready,
  output logic [WIDTH-1:0]       o_wdata,
  output logic                   o_wreq,
  input  logic                   i_fifo_wready,
  output logic [N_REQ-1:0]       o_grant,
  output logic                   o_busy,
  output logic                   o_trunc
);

  localparam int                 c_pw        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [c_pw:0]      c_nreq      = (c_pw + 1)'(N_REQ);
  localparam logic [c_pw-1:0]    c_last_idx  = c_pw'(N_REQ - 1);
  localparam logic [N_REQ-1:0]   c_one       = N_REQ'(1);
  localparam logic [7:0]         c_max_burst = 8'(MAX_BURST);
  localparam logic [7:0]         c_idle_max  = 8'(IDLE_TIMEOUT);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [c_pw-1:0]   rr_ptr_q, rr_ptr_d;
  logic [c_pw-1:0]   owner_q, owner_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic [7:0]        idle_cnt_q, idle_cnt_d;
  logic              trunc_q, trunc_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;

  logic              w_lock;
  logic              w_owner_valid;
  logic              w_owner_last;
  logic              w_xfer;
  logic [N_REQ-1:0]  w_onehot;
  logic [WIDTH-1:0]  w_owner_data;
  logic [7:0]        w_beat_inc;
  logic [7:0]        w_idle_inc;
  logic              w_rel_norm;
  logic              w_rel_burst;
  logic              w_rel_idle;
  logic [c_pw-1:0]   w_pick;
  logic              w_found;
  logic [c_pw:0]     w_idx;

  // First valid requester at or after rr_ptr, wrapping at N_REQ.
  always_comb begin
    w_pick  = rr_ptr_q;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = {1'b0, rr_ptr_q} + (c_pw + 1)'(i);
      if (w_idx >= c_nreq) begin
        w_idx = w_idx - c_nreq;
      end
      if (!w_found && i_req_valid[w_idx[c_pw-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[c_pw-1:0];
      end
    end
  end

  assign w_lock        = (state_q == ST_LOCK);
  assign w_owner_valid = i_req_valid[owner_q];
  assign w_owner_last  = i_req_last[owner_q];
  assign w_owner_data  = i_req_data[int'(owner_q) * WIDTH +: WIDTH];
  assign w_onehot      = c_one << owner_q;
  assign w_xfer        = w_lock & w_owner_valid & i_fifo_wready;
  assign w_beat_inc    = (beat_cnt_q == 8'hFF) ? beat_cnt_q : beat_cnt_q + 8'd1;
  assign w_idle_inc    = (idle_cnt_q == 8'hFF) ? idle_cnt_q : idle_cnt_q + 8'd1;

  // A last on the final allowed beat is a normal release, not a truncation.
  assign w_rel_norm  = w_xfer & w_owner_last;
  assign w_rel_burst = w_xfer & ~w_owner_last & (w_beat_inc >= c_max_burst);
  assign w_rel_idle  = w_lock & ~w_owner_valid & (w_idle_inc >= c_idle_max);

  assign o_req_ready = (w_lock && i_fifo_wready) ? w_onehot : '0;
  assign o_grant     = w_lock ? w_onehot : '0;
  assign o_busy      = w_lock;
  assign o_wreq      = w_xfer;
  assign o_wdata     = w_xfer ? w_owner_data : wdata_q;
  assign o_trunc     = trunc_q;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    idle_cnt_d = idle_cnt_q;
    trunc_d    = 1'b0;
    wdata_d    = wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (w_found) begin
          owner_d    = w_pick;
          beat_cnt_d = 8'd0;
          idle_cnt_d = 8'd0;
          state_d    = ST_LOCK;
        end
      end
      ST_LOCK: begin
        if (w_xfer) begin
          beat_cnt_d = w_beat_inc;
          idle_cnt_d = 8'd0;
          wdata_d    = w_owner_data;
        end else if (!w_owner_valid) begin
          idle_cnt_d = w_idle_inc;
        end else begin
          // Owner is presenting data but the FIFO is full: not idle.
          idle_cnt_d = 8'd0;
        end

        if (w_rel_norm || w_rel_burst || w_rel_idle) begin
          state_d    = ST_IDLE;
          rr_ptr_d   = (owner_q == c_last_idx) ? '0 : owner_q + c_pw'(1);
          beat_cnt_d = 8'd0;
          idle_cnt_d = 8'd0;
          trunc_d    = ~w_rel_norm;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= 8'd0;
      idle_cnt_q <= 8'd0;
      trunc_q    <= 1'b0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      trunc_q    <= trunc_d;
      wdata_q    <= wdata_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sfifo_wr_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_sfifo_wr_arbiter                                                      |
// | Directed scoreboard bench for sfifo_wr_arbiter (MAX_BURST=4).            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_sfifo_wr_arbiter;

  localparam int W     = 8;
  localparam int N     = 4;
  localparam int DEPTH = 32;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic [N-1:0]   i_req_valid;
  logic [N*W-1:0] i_req_data;
  logic [N-1:0]   i_req_last;
  logic [N-1:0]   o_req_ready;
  logic [W-1:0]   o_wdata;
  logic           o_wreq;
  logic           i_fifo_wready;
  logic [N-1:0]   o_grant;
  logic           o_busy;
  logic           o_trunc;

  always #5 clk = ~clk;

  sfifo_wr_arbiter #(
    .WIDTH(W), .N_REQ(N), .MAX_BURST(4), .IDLE_TIMEOUT(8)
  ) dut (
    .clk(clk), .resetn(resetn),
    .i_req_valid(i_req_valid), .i_req_data(i_req_data), .i_req_last(i_req_last),
    .o_req_ready(o_req_ready), .o_wdata(o_wdata), .o_wreq(o_wreq),
    .i_fifo_wready(i_fifo_wready), .o_grant(o_grant), .o_busy(o_busy),
    .o_trunc(o_trunc)
  );

  typedef struct {
    logic [7:0] d;
    bit         l;
  } beat_t;

  beat_t        pq [N][$];
  logic [7:0]   exp_q [$];
  logic [3:0]   gnt_log [$];
  int           tests = 0;
  int           fails = 0;
  int           fifo_cnt = 0;
  int           trunc_cnt = 0;
  logic         s_wreq, s_busy, s_trunc;
  logic [3:0]   s_grant, s_ready;
  logic [3:0]   prev_grant = 4'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int p, input logic [7:0] d, input bit l, input bit ex);
    beat_t b;
    b.d = d;
    b.l = l;
    pq[p].push_back(b);
    if (ex) exp_q.push_back(d);
  endtask

  function automatic bit any_pending();
    bit r = 1'b0;
    for (int n = 0; n < N; n++) if (pq[n].size() > 0) r = 1'b1;
    return r;
  endfunction

  task automatic drive();
    for (int n = 0; n < N; n++) begin
      if (pq[n].size() > 0) begin
        i_req_valid[n]       = 1'b1;
        i_req_data[n*W +: W] = pq[n][0].d;
        i_req_last[n]        = pq[n][0].l;
      end else begin
        i_req_valid[n]       = 1'b0;
        i_req_data[n*W +: W] = '0;
        i_req_last[n]        = 1'b0;
      end
    end
    i_fifo_wready = (fifo_cnt < DEPTH);
  endtask

  task automatic sample();
    s_wreq  = o_wreq;
    s_busy  = o_busy;
    s_trunc = o_trunc;
    s_grant = o_grant;
    s_ready = o_req_ready;
    check("ready_owner_only", o_req_ready & ~o_grant, 0);
    check("wreq_is_transfer", o_wreq, |(i_req_valid & o_req_ready));
    if (o_trunc) trunc_cnt++;
    if (o_grant != 4'd0 && prev_grant == 4'd0) gnt_log.push_back(o_grant);
    prev_grant = o_grant;
    if (o_wreq) begin
      fifo_cnt++;
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_write observed=0x%0h expected=no_write", o_wdata);
      end
      if (exp_q.size() != 0) check("wdata", o_wdata, exp_q.pop_front());
    end
    for (int n = 0; n < N; n++)
      if (i_req_valid[n] && o_req_ready[n]) void'(pq[n].pop_front());
  endtask

  task automatic step();
    drive();
    #2;
    sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    for (int n = 0; n < N; n++) pq[n].delete();
    exp_q.delete();
    step();
    step();
    resetn = 1'b1;
  endtask

  task automatic drain(input int max);
    int k = 0;
    while ((exp_q.size() != 0 || any_pending()) && k < max) begin
      step();
      k++;
    end
    check("drain_in_budget", k < max, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [3:0] rr_exp [5];
    int k;
    i_req_valid = '0; i_req_data = '0; i_req_last = '0; i_fifo_wready = 1'b1;
    @(negedge clk);

    // Reset state with a requester already valid
    push(0, 8'h5A, 1'b1, 1'b0);
    drive();
    #2;
    check("rst_grant", o_grant, 0);
    check("rst_busy",  o_busy, 0);
    check("rst_wreq",  o_wreq, 0);
    check("rst_trunc", o_trunc, 0);
    check("rst_wdata", o_wdata, 0);
    check("rst_ready", o_req_ready, 0);
    @(negedge clk);
    do_reset();

    // Single packet from producer 1
    push(1, 8'hAA, 1'b0, 1'b1); push(1, 8'hEE, 1'b0, 1'b1); push(1, 8'hFF, 1'b1, 1'b1);
    step(); check("t1_idle_grant", s_grant, 0); check("t1_idle_wreq", s_wreq, 0);
    step(); check("t1_grant", s_grant, 4'b0010); check("t1_busy", s_busy, 1); check("t1_wreq0", s_wreq, 1);
    step(); check("t1_wreq1", s_wreq, 1);
    step(); check("t1_wreq2", s_wreq, 1);
    step(); check("t1_release", s_grant, 0); check("t1_busy_off", s_busy, 0);
    check("t1_all_written", exp_q.size(), 0);

    // Round robin after reset
    do_reset();
    gnt_log.delete(); fifo_cnt = 0;
    for (int n = 0; n < N; n++) begin
      push(n, 8'(16*n), 1'b0, 1'b1);
      push(n, 8'(16*n + 1), 1'b1, 1'b1);
    end
    push(0, 8'h02, 1'b0, 1'b1); push(0, 8'h03, 1'b1, 1'b1);
    drain(100);
    step(); step();
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    check("t2_grant_count", gnt_log.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < gnt_log.size()) check("t2_grant_order", gnt_log[i], rr_exp[i]);

    // FIFO full backpressure from producer 2
    fifo_cnt = 0; trunc_cnt = 0;
    for (int i = 0; i < 33; i++) push(2, 8'(64 + i), (i % 4 == 3) || (i == 32), 1'b1);
    k = 0;
    while (fifo_cnt < DEPTH && k < 200) begin step(); k++; end
    check("t3_fill", fifo_cnt, DEPTH);
    for (int i = 0; i < 12; i++) begin
      step();
      check("t3_full_wreq", s_wreq, 0);
      check("t3_full_ready", s_ready[2], 0);
    end
    check("t3_stall_locked", s_grant, 4'b0100);
    fifo_cnt--;
    step(); check("t3_one_accept", s_wreq, 1);
    check("t3_refull", fifo_cnt, DEPTH);
    step(); check("t3_after", s_wreq, 0);
    check("t3_no_trunc", trunc_cnt, 0);
    check("t3_all_written", exp_q.size(), 0);

    // MAX_BURST=4 truncation, grant passes to producer 1, then back to 0
    fifo_cnt = 0; trunc_cnt = 0; gnt_log.delete();
    for (int i = 0; i < 6; i++) push(0, 8'(80 + i), 1'b0, 1'b0);
    push(1, 8'h60, 1'b1, 1'b0);
    exp_q = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h60, 8'h54, 8'h55};
    step(); check("t4_arb", s_grant, 0);
    for (int i = 0; i < 4; i++) begin step(); check("t4_burst_wreq", s_wreq, 1); end
    step(); check("t4_trunc", s_trunc, 1); check("t4_released", s_grant, 0);
    step(); check("t4_trunc_once", s_trunc, 0); check("t4_next_owner", s_grant, 4'b0010);
    drain(100);
    for (int i = 0; i < 12; i++) step();
    check("t4_trunc_total", trunc_cnt, 2);
    check("t4_grant_count", gnt_log.size(), 3);
    if (gnt_log.size() == 3) check("t4_regrant0", gnt_log[2], 4'b0001);
    check("t4_idle", s_grant, 0);

    // Owner idle timeout; others wait, rr wraps to 0
    do_reset();
    trunc_cnt = 0; gnt_log.delete(); fifo_cnt = 0;
    push(3, 8'h70, 1'b0, 1'b1);
    step(); check("t5_idle", s_grant, 0);
    step(); check("t5_grant3", s_grant, 4'b1000); check("t5_wreq", s_wreq, 1);
    push(0, 8'h80, 1'b1, 1'b1); push(1, 8'h81, 1'b1, 1'b1); push(2, 8'h82, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step();
      check("t5_hold", s_grant, 4'b1000);
      check("t5_no_trunc_yet", s_trunc, 0);
    end
    step(); check("t5_trunc", s_trunc, 1); check("t5_released", s_grant, 0);
    step(); check("t5_trunc_once", s_trunc, 0); check("t5_rr_wrap", s_grant, 4'b0001);
    drain(50);
    step(); step();
    check("t5_trunc_total", trunc_cnt, 1);

    // Reset in the middle of a 4-beat packet
    fifo_cnt = 0;
    push(1, 8'h90, 1'b0, 1'b1); push(1, 8'h91, 1'b0, 1'b0);
    push(1, 8'h92, 1'b0, 1'b0); push(1, 8'h93, 1'b1, 1'b0);
    step();
    step(); check("t6_beat0", s_wreq, 1); check("t6_grant", s_grant, 4'b0010);
    drive();
    #1 resetn = 1'b0;
    #1;
    check("t6_rst_grant", o_grant, 0);
    check("t6_rst_wreq", o_wreq, 0);
    check("t6_rst_busy", o_busy, 0);
    check("t6_rst_ready", o_req_ready, 0);
    #6 resetn = 1'b1;
    @(negedge clk);
    pq[1].delete(); gnt_log.delete(); prev_grant = 4'd0;
    push(3, 8'hA3, 1'b1, 1'b0); push(0, 8'hA0, 1'b1, 1'b0);
    exp_q = '{8'hA0, 8'hA3};
    drain(50);
    step();
    check("t6_grant_count", gnt_log.size(), 2);
    if (gnt_log.size() == 2) begin
      check("t6_restart_p0", gnt_log[0], 4'b0001);
      check("t6_then_p3", gnt_log[1], 4'b1000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
